// File: rtl/global_buffer_loader.sv
// Global buffer loader: accepts a tagged valid/ready word stream, writes it
// into the lower half of the global buffer from address 0, then starts the
// PE array and waits for it to finish before another load is accepted.
module global_buffer_loader #(
  parameter int DATA_WIDTH        = 4,
  parameter int KB                = 32,
  parameter int SIZE_GLOBAL       = (KB * 8192) / DATA_WIDTH,
  parameter int ADDR_WIDTH_GLOBAL = $clog2(SIZE_GLOBAL),
  parameter int LOAD_LIMIT        = SIZE_GLOBAL / 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_req,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic [1:0]                   s_tag,
  input  logic                         s_last,
  output logic                         wen_global,
  output logic [ADDR_WIDTH_GLOBAL-1:0] w_addr,
  output logic [DATA_WIDTH+1:0]        w_data,
  output logic [ADDR_WIDTH_GLOBAL-1:0] last_global_index,
  output logic                         start,
  input  logic                         finish_in,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, LAUNCH, RUN, ERR} state_t;

  state_t                       state;
  state_t                       state_next;
  logic [ADDR_WIDTH_GLOBAL-1:0] count;
  logic                         accept;
  logic                         at_limit;
  logic                         session_go;

  assign accept     = s_valid & s_ready;
  assign at_limit   = (count == ADDR_WIDTH_GLOBAL'(LOAD_LIMIT - 1));
  assign session_go = load_req & ((state == IDLE) | (state == ERR));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; s_last on the limit beat is a legal full load
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (load_req) state_next = LOAD;
      LOAD: begin
        if (accept && s_last)        state_next = DRAIN;
        else if (accept && at_limit) state_next = ERR;
      end
      DRAIN:   state_next = LAUNCH;
      LAUNCH:  state_next = RUN;
      RUN:     if (finish_in) state_next = IDLE;
      ERR:     if (load_req) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; s_ready has no path from s_valid
  always_comb begin
    s_ready = (state == LOAD);
    start   = (state == LAUNCH);
    busy    = (state != IDLE) && (state != ERR);
  end

  // Registered write port, beat counter, result index and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      count             <= '0;
      wen_global        <= 1'b0;
      w_addr            <= '0;
      w_data            <= '0;
      last_global_index <= '0;
      error             <= 1'b0;
      done              <= 1'b0;
    end else begin
      wen_global <= accept;
      done       <= (state == RUN) && finish_in;
      if (session_go) begin
        count <= '0;
        error <= 1'b0;
      end else if (accept) begin
        count  <= count + 1'b1;
        w_addr <= count;
        w_data <= {s_tag, s_data};
        if (s_last)        last_global_index <= count;
        else if (at_limit) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_global_buffer_loader.sv
// Scoreboard bench for global_buffer_loader with a small load limit so the
// overflow and full-load boundaries are reachable.
module tb_global_buffer_loader;

  localparam int DW    = 4;
  localparam int AW    = 16;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_req = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [1:0]    s_tag = '0;
  logic          s_last = 1'b0;
  logic          wen_global;
  logic [AW-1:0] w_addr;
  logic [DW+1:0] w_data;
  logic [AW-1:0] last_global_index;
  logic          start;
  logic          finish_in = 1'b0;
  logic          busy;
  logic          done;
  logic          error;

  global_buffer_loader #(
    .DATA_WIDTH(DW),
    .KB(32),
    .LOAD_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .load_req(load_req),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
    .s_last(s_last), .wen_global(wen_global), .w_addr(w_addr), .w_data(w_data),
    .last_global_index(last_global_index), .start(start), .finish_in(finish_in),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW+1:0] data;
  } wr_t;

  wr_t           wq[$];
  int            sq[$];
  int            dq[$];
  wr_t           e;
  int            ec;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] exp_lgi = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write / start / done the DUT shows is matched in order
  always @(negedge clk) begin
    if (wen_global === 1'b1) begin
      if (wq.size() == 0) chk("unexpected_write", wen_global, 0);
      else begin
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", w_addr, e.addr);
        chk("wr_data", w_data, e.data);
      end
    end
    if (start === 1'b1) begin
      if (sq.size() == 0) chk("unexpected_start", start, 0);
      else begin
        ec = sq.pop_front();
        chk("start_cycle", cyc, ec);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) chk("unexpected_done", done, 0);
      else begin
        ec = dq.pop_front();
        chk("done_cycle", cyc, ec);
      end
    end
  end

  // gaps: 0 none, 1 random, 2 fixed pattern giving valid 1,0,0,1,0,1
  task automatic run_load(input int n, input bit with_last, input int gaps,
                          input bit directed, input int run_wait, input bit noise);
    bit            ok;
    int            nacc;
    int            ng;
    int            acc_cyc;
    logic [DW-1:0] d;
    logic [1:0]    t;
    ok   = with_last && (n <= LIMIT);
    nacc = ok ? n : LIMIT;
    acc_cyc = cyc;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("s_ready_load", s_ready, 1);
    chk("busy_load", busy, 1);
    chk("error_clear", error, 0);
    for (int i = 0; i < nacc; i++) begin
      ng = (gaps == 1) ? int'($urandom_range(0, 2)) :
           (gaps == 2) ? ((i == 1) ? 2 : (i == 2) ? 1 : 0) : 0;
      for (int g = 0; g < ng; g++) begin
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        if (noise) begin
          load_req  = 1'($urandom_range(0, 1));
          finish_in = 1'($urandom_range(0, 1));
        end
        step();
      end
      d = directed ? DW'(i + 1) : DW'($urandom);
      t = directed ? ((i == 2) ? 2'd1 : 2'd0) : 2'($urandom);
      s_valid = 1'b1;
      s_data  = d;
      s_tag   = t;
      s_last  = with_last && (i == n - 1);
      if (noise) begin
        load_req  = 1'($urandom_range(0, 1));
        finish_in = 1'($urandom_range(0, 1));
      end
      wq.push_back(wr_t'{cyc + 1, AW'(i), {t, d}});
      acc_cyc = cyc;
      step();
    end
    s_valid = 1'b0; s_last = 1'b0; load_req = 1'b0; finish_in = 1'b0;
    if (ok) begin
      exp_lgi = AW'(n - 1);
      sq.push_back(acc_cyc + 2);
      chk("busy_drain", busy, 1);
      step();
      step();
      for (int w = 0; w < run_wait; w++) begin
        if (noise) load_req = 1'($urandom_range(0, 1));
        chk("busy_run", busy, 1);
        chk("s_ready_run", s_ready, 0);
        step();
        load_req = 1'b0;
      end
      finish_in = 1'b1;
      dq.push_back(cyc + 1);
      step();
      finish_in = 1'b0;
      step();
      chk("busy_idle", busy, 0);
      chk("s_ready_idle", s_ready, 0);
      chk("lgi_done", last_global_index, exp_lgi);
      chk("error_ok", error, 0);
    end else begin
      chk("error_set", error, 1);
      chk("s_ready_err", s_ready, 0);
      chk("busy_err", busy, 0);
      chk("lgi_err", last_global_index, exp_lgi);
      for (int w = 0; w < 3; w++) begin
        finish_in = 1'($urandom_range(0, 1));
        step();
      end
      finish_in = 1'b0;
      chk("error_sticky", error, 1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_wen"}, wen_global, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_w_data"}, w_data, 0);
    chk({tag, "_lgi"}, last_global_index, 0);
  endtask

  task automatic reset_mid_load();
    logic [DW-1:0] d;
    logic [1:0]    t;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = DW'($urandom);
      t = 2'($urandom);
      s_valid = 1'b1; s_data = d; s_tag = t;
      wq.push_back(wr_t'{cyc + 1, AW'(i), {t, d}});
      step();
    end
    s_data = DW'($urandom);
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_valid = 1'b0;
    exp_lgi = '0;
    check_reset_state("mid_rst");
  endtask

  initial begin
    int  n;
    bit  wl;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;
    step();
    run_load(3, 1'b1, 0, 1'b1, 4, 1'b0);
    run_load(1, 1'b1, 0, 1'b0, 5, 1'b0);
    run_load(5, 1'b0, 0, 1'b0, 0, 1'b0);
    run_load(LIMIT, 1'b1, 0, 1'b0, 2, 1'b0);
    run_load(3, 1'b1, 2, 1'b0, 2, 1'b0);
    run_load(4, 1'b1, 1, 1'b0, 3, 1'b1);
    reset_mid_load();
    run_load(2, 1'b1, 0, 1'b0, 1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      n  = int'($urandom_range(1, 6));
      wl = (n < LIMIT) ? 1'b1 : 1'($urandom_range(0, 1));
      run_load(n, wl, int'($urandom_range(0, 1)), 1'b0,
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end
    for (int w = 0; w < 4; w++) step();
    chk("writes_pending", wq.size(), 0);
    chk("starts_pending", sq.size(), 0);
    chk("dones_pending", dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/global_buffer_loader.md
Name: global_buffer_loader

Overview:
- Upstream feeder of the PE-array top level.
- Accepts an external valid/ready stream of tagged input words (ifmap/filter data plus 2-bit tag) and writes them into the lower half of the global buffer SRAM, starting at address 0.
- Then presents last_global_index, issues a one-cycle start pulse to the array, and waits for the array's finish before it accepts a new load.

Parameters:
DATA_WIDTH, 4, data bits per word (global buffer word = DATA_WIDTH+2).
KB, 32, global buffer capacity in KB.
SIZE_GLOBAL, (KB*8192)/DATA_WIDTH, global buffer depth in words.
ADDR_WIDTH_GLOBAL, $clog2(SIZE_GLOBAL), global buffer address width.
LOAD_LIMIT, SIZE_GLOBAL/2, maximum words per load; the upper half is reserved for results.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
load_req  in  1  pulse; begins a load session (sampled in IDLE or ERR only).
s_valid  in  1  stream word valid.
s_ready  out  1  stream word ready.
s_data  in  DATA_WIDTH  stream data.
s_tag  in  2  stream tag; written unchanged into the top 2 bits.
s_last  in  1  marks the final word of the load.
wen_global  out  1  global buffer write enable.
w_addr  out  ADDR_WIDTH_GLOBAL  global buffer write address.
w_data  out  DATA_WIDTH+2  write word = {s_tag, s_data}.
last_global_index  out  ADDR_WIDTH_GLOBAL  address of the final word of the last completed load.
start  out  1  one-cycle pulse to the PE array.
finish_in  in  1  array finished (level or pulse).
busy  out  1  high in every state except IDLE and ERR.
done  out  1  one-cycle pulse when the session completes.
error  out  1  overflow flag; sticky.

Behaviour:
- Reset: state=IDLE. s_ready, wen_global, start, busy, done and error are 0. w_addr, w_data, last_global_index and the beat counter are 0.
- States: IDLE, LOAD, DRAIN, LAUNCH, RUN, ERR.
- IDLE: s_ready=0.
  - load_req=1 -> LOAD; beat counter cleared to 0.
- LOAD: s_ready=1. A beat is accepted when s_valid&s_ready. For each accepted beat, next cycle:
  - wen_global=1
  - w_addr = counter
  - w_data = {s_tag, s_data}
  - counter += 1
  - The write is registered, so there is 1 cycle of latency from acceptance to write.
- LOAD, other cycles: wen_global=0 in any cycle with no accepted beat; s_valid gaps are allowed and there is no timeout.
- LOAD exits:
  - Accepted beat with s_last=1: last_global_index <= counter at that beat; -> DRAIN.
  - Accepted beat with counter==LOAD_LIMIT-1 and s_last=0: the beat is still written; error <= 1; -> ERR. last_global_index is unchanged.
  - If both apply (s_last=1 at counter LOAD_LIMIT-1), this is a legal full load -> DRAIN.
- DRAIN: s_ready=0; the final write occurs this cycle. Always -> LAUNCH.
- LAUNCH: start=1 for exactly this cycle, so start rises 2 cycles after the final beat is accepted. Always -> RUN.
- RUN: s_ready=0, waits for the array.
  - finish_in=1 -> IDLE, with done=1 in the cycle after finish_in is seen.
  - finish_in is ignored in all other states.
- ERR: s_ready=0, error=1, busy=0.
  - load_req=1 -> LOAD, clears error and the counter.
- load_req outside IDLE/ERR: ignored, no effect.
- Single-word load (s_last on the first beat): last_global_index=0.
- last_global_index holds its value across sessions until the next successful s_last.
- rst while in any state returns all of the above to reset values next cycle; an in-flight write is dropped (wen_global=0).
- No combinational path from s_valid to s_ready. s_ready depends on state only.

Test Plan:
- Load 3 words, data 1,2,3, tags 0,0,1, s_last on word 3, s_valid continuous -> writes at addresses 0,1,2 with w_data 6'h01,6'h02,6'h13; last_global_index=2; start pulses exactly 2 cycles after beat 3 is accepted; busy=1 until done.
- Single word with s_last -> one write to address 0; last_global_index=0; start one cycle after the write cycle; finish_in 5 cycles later -> done pulses 1 cycle after finish_in, state IDLE, busy=0.
- LOAD_LIMIT=4, 5 words with no s_last -> 4 writes (addresses 0..3), error=1, s_ready=0, no start pulse; next load_req clears error and writes at address 0. Repeat with s_last on word 4 -> legal full load, last_global_index=3, no error.
- Backpressure: s_valid toggles 1,0,0,1,0,1 for 3 words -> exactly 3 writes at addresses 0,1,2; wen_global low in gap cycles; no duplicates.
- load_req pulsed during LOAD and RUN -> ignored; counter and addresses unaffected; finish_in pulsed during LOAD -> ignored.
- rst asserted mid-LOAD after 2 beats -> next cycle state IDLE, all outputs 0 (last_global_index=0); the following load restarts at address 0.
